cube_l0_wide_packer: RTL

//  Upstream feeder for the cube v2 accelerator's L0A/L0B load path. Accepts one load command
//  (target buffer + entry index) and a 64-bit beat stream, then drives the cube's MMIO port.
//  Per entry it issues the control-register load command, packs 2x32 beats into two 2048-bit

---
 rtl/cube_l0_wide_packer_if.sv | 44 ++++
 rtl/cube_l0_wide_packer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/cube_l0_wide_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cube_l0_wide_packer_if                                          |
// | Purpose  : Command, beat-stream and cube MMIO bundle for the L0 packer.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface cube_l0_wide_packer_if #(
  parameter int BEAT_W = 64,
  parameter int WIDE_W = 2048
);
  // Load command
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_target;
  logic [6:0]        cmd_entry;
  // Beat stream
  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] in_data;
  // Cube MMIO port
  logic              mem_wvalid;
  logic [63:0]       mem_waddr;
  logic [BEAT_W-1:0] mem_wdata;
  logic [WIDE_W-1:0] mem_wdata_wide;
  logic              mem_wdata_wide_valid;
  // Status
  logic              busy;
  logic              load_done;

  // Feeder side: offers commands and beats, observes the cube port
  modport master (
    output cmd_valid, cmd_target, cmd_entry, in_valid, in_data,
    input  cmd_ready, in_ready, mem_wvalid, mem_waddr, mem_wdata,
           mem_wdata_wide, mem_wdata_wide_valid, busy, load_done
  );

  // Packer side
  modport slave (
    input  cmd_valid, cmd_target, cmd_entry, in_valid, in_data,
    output cmd_ready, in_ready, mem_wvalid, mem_waddr, mem_wdata,
           mem_wdata_wide, mem_wdata_wide_valid, busy, load_done
  );
endinterface
`default_nettype wire

// File: rtl/cube_l0_wide_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cube_l0_wide_packer                                             |
// | Purpose  : Issues the cube L0A/L0B load command, then packs 64-bit beats   |
// |            into two wide halves, each presented as a one-cycle pulse.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cube_l0_wide_packer #(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          BEAT_W    = 64,
  parameter int          WIDE_W    = 2048
) (
  input wire logic             clk,
  input wire logic             rst_n,
  cube_l0_wide_packer_if.slave bus
);

  localparam int BEATS = WIDE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_FILL = 3'd2;
  localparam logic [2:0] S_PUSH = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              half_q, half_d;
  logic              mem_wvalid_q, mem_wvalid_d;
  logic [63:0]       mem_waddr_q, mem_waddr_d;
  logic [BEAT_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wide_valid_q, wide_valid_d;
  logic              load_done_q, load_done_d;
  logic [WIDE_W-1:0] wide_q;

  logic              w_cmd_fire;
  logic              w_beat_fire;
  logic              w_last_beat;
  logic [BEAT_W-1:0] w_cmd_word;

  assign w_cmd_fire  = (state_q == S_IDLE) && bus.cmd_valid;
  assign w_beat_fire = (state_q == S_FILL) && bus.in_valid;
  assign w_last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));

  // Control-register load word: bit 2 selects L0A, bit 3 selects L0B, entry in [14:8]
  always_comb begin
    w_cmd_word        = '0;
    w_cmd_word[2]     = ~bus.cmd_target;
    w_cmd_word[3]     = bus.cmd_target;
    w_cmd_word[14:8]  = bus.cmd_entry;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_cmd_fire) state_d = S_CMD;
      S_CMD:   state_d = S_FILL;
      S_FILL:  if (w_beat_fire && w_last_beat) state_d = S_PUSH;
      S_PUSH:  state_d = half_q ? S_DONE : S_FILL;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/next-value logic; strobes are decoded from the upcoming state so they land registered
  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    half_d       = half_q;
    mem_wvalid_d = 1'b0;
    mem_waddr_d  = '0;
    mem_wdata_d  = '0;
    wide_valid_d = (state_d == S_PUSH);
    load_done_d  = (state_d == S_DONE);
    if (w_beat_fire) beat_cnt_d = beat_cnt_q + 1'b1;
    if (state_q == S_PUSH && !half_q) half_d = 1'b1;
    if (state_q == S_DONE) half_d = 1'b0;
    if (state_d == S_CMD) begin
      mem_wvalid_d = 1'b1;
      mem_waddr_d  = BASE_ADDR;
      mem_wdata_d  = w_cmd_word;
    end
  end

  // Registered outputs and sequencing counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q   <= '0;
      half_q       <= 1'b0;
      mem_wvalid_q <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
      wide_valid_q <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      half_q       <= half_d;
      mem_wvalid_q <= mem_wvalid_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
      wide_valid_q <= wide_valid_d;
      load_done_q  <= load_done_d;
    end
  end

  // Assembly register: each accepted beat lands in its slot; contents persist between halves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wide_q <= '0;
    end else if (w_beat_fire) begin
      wide_q[int'(beat_cnt_q) * BEAT_W +: BEAT_W] <= bus.in_data;
    end
  end

  assign bus.cmd_ready            = (state_q == S_IDLE);
  assign bus.in_ready             = (state_q == S_FILL);
  assign bus.busy                 = (state_q != S_IDLE);
  assign bus.mem_wvalid           = mem_wvalid_q;
  assign bus.mem_waddr            = mem_waddr_q;
  assign bus.mem_wdata            = mem_wdata_q;
  assign bus.mem_wdata_wide       = wide_q;
  assign bus.mem_wdata_wide_valid = wide_valid_q;
  assign bus.load_done            = load_done_q;

endmodule
`default_nettype wire
